// File: rtl/tnn_neuron_scheduler_if.sv
// Frame, config and result handshake bundle for the TNN neuron scheduler.
interface tnn_neuron_scheduler_if #(
  parameter int unsigned W         = 3,
  parameter int unsigned N_NEURONS = 6
);
  localparam int unsigned AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [N_NEURONS*W-1:0]    in_a;
  logic [N_NEURONS*W-1:0]    in_b;
  logic                      cfg_we;
  logic [AW-1:0]             cfg_addr;
  logic [W-1:0]              cfg_data;
  logic                      cfg_busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_NEURONS-1:0]      out_bits;

  modport master (
    output in_valid, in_a, in_b, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_busy, out_valid, out_bits
  );

  modport slave (
    input  in_valid, in_a, in_b, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_busy, out_valid, out_bits
  );
endinterface

// File: rtl/tnn_neuron_scheduler.sv
// Time-multiplexed sum-threshold evaluation of one TNN layer frame, one neuron
// per cycle, with a per-neuron threshold register file.

// Exact compare leaf: out = (a + b) >= c without overflow; approximate variants
// replace this module with the same ports.
module tnn_cmp_exact #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out
);
  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    out = (sum >= {1'b0, c});
  end
endmodule

module tnn_neuron_scheduler #(
  parameter int unsigned W         = 3,
  parameter int unsigned N_NEURONS = 6,
  parameter logic [W-1:0] THR_RESET = W'(4)
) (
  input  logic                   clk,
  input  logic                   rst,
  tnn_neuron_scheduler_if.slave  bus
);
  localparam int unsigned AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [AW-1:0]  idx;
  logic [W-1:0]   frame_a [N_NEURONS];
  logic [W-1:0]   frame_b [N_NEURONS];
  logic [W-1:0]   thr     [N_NEURONS];
  logic           cmp_out;

  logic                 in_ready_q;
  logic                 cfg_busy_q;
  logic                 out_valid_q;
  logic [N_NEURONS-1:0] out_bits_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.cfg_busy  = cfg_busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bits  = out_bits_q;

  tnn_cmp_exact #(.W(W)) u_cmp (
    .a   (frame_a[idx]),
    .b   (frame_b[idx]),
    .c   (thr[idx]),
    .out (cmp_out)
  );

  // Scheduler FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      cfg_busy_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        thr[i]     <= THR_RESET;
        frame_a[i] <= '0;
        frame_b[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          // Config writes only land while idle; out-of-range addresses are dropped.
          if (bus.cfg_we && ({1'b0, bus.cfg_addr} < (AW+1)'(N_NEURONS))) begin
            thr[bus.cfg_addr] <= bus.cfg_data;
          end
          if (bus.in_valid) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
              frame_a[i] <= bus.in_a[i*W +: W];
              frame_b[i] <= bus.in_b[i*W +: W];
            end
            out_bits_q <= '0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            cfg_busy_q <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          out_bits_q[idx] <= cmp_out;
          if (idx == AW'(N_NEURONS - 1)) begin
            idx         <= '0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cfg_busy_q  <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          idx         <= '0;
          in_ready_q  <= 1'b1;
          cfg_busy_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tnn_neuron_scheduler.sv
// Directed-vector bench for tnn_neuron_scheduler with a small reference model.
module tb_tnn_neuron_scheduler;
  localparam int unsigned W  = 3;
  localparam int unsigned N  = 6;
  localparam int unsigned FW = N * W;
  localparam int unsigned NV = 7;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  tnn_neuron_scheduler_if #(.W(W), .N_NEURONS(N)) bus ();

  tnn_neuron_scheduler #(.W(W), .N_NEURONS(N), .THR_RESET(3'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    logic [FW-1:0] thr;
    bit            wr;
    logic [N-1:0]  exp;
    string         name;
  } vec_t;

  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] rep(input logic [W-1:0] v);
    logic [FW-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [FW-1:0] pk(input logic [W-1:0] v5, v4, v3, v2, v1, v0);
    return {v5, v4, v3, v2, v1, v0};
  endfunction

  function automatic logic [N-1:0] model(input logic [FW-1:0] a, b, thr);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++)
      r[i] = (int'(a[i*W +: W]) + int'(b[i*W +: W])) >= int'(thr[i*W +: W]);
    return r;
  endfunction

  task automatic wr_thr(input logic [FW-1:0] thr);
    for (int i = 0; i < int'(N); i++) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(i);
      bus.cfg_data = thr[i*W +: W];
      tick();
    end
    bus.cfg_we = 1'b0;
  endtask

  task automatic run_frame(input logic [FW-1:0] a, b, input logic [N-1:0] exp, input string nm);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin tick(); k++; end
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a = FW'($urandom);
    bus.in_b = FW'($urandom);
    k = 0;
    while (!bus.out_valid && k < 20) begin tick(); k++; end
    chk({nm, "_latency"}, 32'(k), 32'(N));
    chk({nm, "_bits"}, 32'(bus.out_bits), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [FW-1:0] ra, rb, rt;
    logic [N-1:0]  held;
    int            acc [$];
    int            bad;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.out_ready = 1'b0;

    vt[0] = '{rep(3'd2), rep(3'd2), '0, 1'b0, 6'b111111, "default_thr"};
    vt[1] = '{rep(3'd3), rep(3'd2), pk(5,4,3,2,1,0), 1'b1, 6'b111111, "thr_ramp_sum5"};
    vt[2] = '{rep(3'd1), rep(3'd1), '0, 1'b0, 6'b000111, "thr_ramp_sum2"};
    vt[3] = '{rep(3'd7), rep(3'd7), rep(3'd7), 1'b1, 6'b111111, "overflow_7_7"};
    vt[4] = '{pk(5,6,4,0,0,7), pk(5,0,3,3,0,7), pk(2,7,7,4,0,7), 1'b1, 6'b101011, "mixed"};
    vt[5] = '{rep(3'd0), rep(3'd0), rep(3'd0), 1'b1, 6'b111111, "zero_zero_thr0"};
    vt[6] = '{rep(3'd0), rep(3'd3), rep(3'd4), 1'b1, 6'b000000, "sum3_thr4"};

    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_bits", 32'(bus.out_bits), 32'd0);
    chk("rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);

    for (int v = 0; v < int'(NV); v++) begin
      if (vt[v].wr) wr_thr(vt[v].thr);
      run_frame(vt[v].a, vt[v].b, vt[v].exp, vt[v].name);
    end

    // Backpressure with cfg writes attempted during RUN and DONE.
    wr_thr(rep(3'd4));
    bus.in_a = rep(3'd2); bus.in_b = rep(3'd2); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("bp_cfg_busy_run", 32'(bus.cfg_busy), 32'd1);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_data = 3'd7;
    for (int i = 0; i < int'(N); i++) tick();
    chk("bp_valid_up", 32'(bus.out_valid), 32'd1);
    held = bus.out_bits;
    chk("bp_bits", 32'(held), 32'h3f);
    bus.cfg_addr = 3'd0;
    bus.in_valid = 1'b1; bus.in_a = rep(3'd0); bus.in_b = rep(3'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_valid || bus.out_bits !== held || bus.in_ready) bad++;
    end
    chk("bp_hold_10", 32'(bad), 32'd0);
    bus.in_valid = 1'b0; bus.cfg_we = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_release", 32'(bus.out_valid), 32'd0);
    run_frame(rep(3'd2), rep(3'd2), 6'b111111, "bp_cfg_dropped");

    // Reset in the third RUN cycle.
    wr_thr(rep(3'd7));
    bus.in_a = rep(3'd2); bus.in_b = rep(3'd2); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_bits", 32'(bus.out_bits), 32'd0);
    chk("mid_rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.out_valid) bad++; end
    chk("mid_rst_no_output", 32'(bad), 32'd0);
    run_frame(rep(3'd2), rep(3'd2), 6'b111111, "mid_rst_thr_reset");

    // Back-to-back streaming with out_ready tied high.
    rt = pk(6,5,4,3,2,1);
    wr_thr(rt);
    bus.in_a = pk(1,2,3,0,1,0); bus.in_b = pk(4,2,1,3,0,1);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.in_ready) acc.push_back(c);
      if (bus.out_valid && bus.out_bits !== model(bus.in_a, bus.in_b, rt)) bad++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("b2b_bits", 32'(bad), 32'd0);
    chk("b2b_accepts", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(N + 2));
    tick();
    bus.out_ready = 1'b0;
    tick();

    // Randomized frames against the reference model.
    for (int f = 0; f < 200; f++) begin
      rt = FW'($urandom);
      ra = FW'($urandom);
      rb = FW'($urandom);
      wr_thr(rt);
      run_frame(ra, rb, model(ra, rb, rt), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
